// File: rtl/i2s_rx_ctrl.sv
// Capture sequencer for the i2s_rx core: latches one stereo frame per ws period
// and pushes the selected channel words into a show-ahead FIFO for the bus side.
module i2s_rx_ctrl #(
  parameter int FIFO_DEPTH    = 8,
  parameter int LVL_W         = 4,
  parameter int CAPTURE_DELAY = 2
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [LVL_W-1:0] threshold,
  input  logic             ws,
  input  logic [63:0]      rx_data,
  input  logic             pop,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             overflow,
  output logic [15:0]      frame_count,
  output logic             irq
);

  localparam int PTR_W = LVL_W - 1;
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_DELAY  = 3'd3;
  localparam logic [2:0] S_CAP    = 3'd4;
  localparam logic [2:0] S_PUSH_L = 3'd5;
  localparam logic [2:0] S_PUSH_R = 3'd6;

  logic [2:0]       state;
  logic [3:0]       cnt;
  logic             ws_d;
  logic             stereo;
  logic [63:0]      hold;
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  logic             frame_end;
  logic             push_req;
  logic [31:0]      push_word;
  logic             do_push;
  logic             do_pop;
  logic [LVL_W-1:0] level_nxt;

  function automatic logic [LVL_W-1:0] level_step(input logic [LVL_W-1:0] l,
                                                  input logic up, input logic dn);
    logic [LVL_W-1:0] r;
    r = l;
    if (up && !dn)
      r = l + LVL_W'(1);
    else if (dn && !up)
      r = l - LVL_W'(1);
    return r;
  endfunction

  assign frame_end = ws_d & ~ws;

  // Pushes are gated by en so an abandoned capture never reaches the FIFO.
  always_comb begin
    push_req  = en && ((state == S_PUSH_L) || (state == S_PUSH_R));
    push_word = (state == S_PUSH_R) ? hold[63:32] : hold[31:0];
    do_pop    = pop && (level != '0);
    do_push   = push_req && (!full || do_pop);
    level_nxt = level_step(level, do_push, do_pop);
  end

  // Sequencer: ws edge detect and capture FSM
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= S_IDLE;
      cnt    <= '0;
      ws_d   <= 1'b0;
      stereo <= 1'b0;
    end else begin
      ws_d <= ws;
      if (clr)
        state <= en ? S_SYNC : S_IDLE;
      else if (!en)
        state <= S_IDLE;
      else begin
        case (state)
          S_IDLE: state <= S_SYNC;
          S_SYNC: if (frame_end) state <= S_WAIT;
          S_WAIT:
            if (frame_end) begin
              if (CAPTURE_DELAY == 0)
                state <= S_CAP;
              else begin
                state <= S_DELAY;
                cnt   <= 4'(CAPTURE_DELAY);
              end
            end
          S_DELAY: begin
            cnt <= cnt - 4'd1;
            if (cnt <= 4'd1) state <= S_CAP;
          end
          S_CAP: begin
            stereo <= (mode == 2'b10);
            state  <= (mode == 2'b01) ? S_PUSH_R : S_PUSH_L;
          end
          S_PUSH_L: state <= stereo ? S_PUSH_R : S_WAIT;
          S_PUSH_R: state <= S_WAIT;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (state == S_CAP) hold <= rx_data;
  end

  // FIFO control, status and frame counter
  always_ff @(posedge HCLK) begin
    if (HRESET || clr) begin
      wptr        <= '0;
      rptr        <= '0;
      level       <= '0;
      overflow    <= 1'b0;
      frame_count <= '0;
      irq         <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      level <= level_nxt;
      if (push_req && !do_push) overflow <= 1'b1;
      if (en && (state == S_CAP)) frame_count <= frame_count + 16'd1;
      irq <= (threshold != '0) && (level_nxt >= threshold);
    end
  end

  always_ff @(posedge HCLK) begin
    if (do_push && !clr) mem[wptr] <= push_word;
  end

  assign rd_valid = (level != '0);
  assign full     = (level == DEPTH_L);
  assign rd_data  = rd_valid ? mem[rptr] : 32'h0;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Directed bench for i2s_rx_ctrl: a table of frame/pop/clear steps with expected
// status, followed by cycle-accurate sequences for latency, en abort and reset.
module tb_i2s_rx_ctrl;

  localparam int LVL_W = 4;
  localparam int OP_FRAME = 0;
  localparam int OP_POP   = 1;
  localparam int OP_CLR   = 2;

  logic             HCLK;
  logic             HRESET;
  logic             en;
  logic             clr;
  logic [1:0]       mode;
  logic [LVL_W-1:0] threshold;
  logic             ws;
  logic [63:0]      rx_data;
  logic             pop;
  logic [31:0]      rd_data;
  logic             rd_valid;
  logic [LVL_W-1:0] level;
  logic             full;
  logic             overflow;
  logic [15:0]      frame_count;
  logic             irq;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int          op;
    logic [1:0]  mode;
    logic [3:0]  thr;
    logic [63:0] rx;
    int          lvl;
    logic [31:0] rd;
    bit          ovf;
    bit          full;
    int          fc;
    bit          irq;
  } vec_t;

  vec_t tbl[$];

  i2s_rx_ctrl #(.FIFO_DEPTH(8), .LVL_W(LVL_W), .CAPTURE_DELAY(2)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .en(en), .clr(clr), .mode(mode),
    .threshold(threshold), .ws(ws), .rx_data(rx_data), .pop(pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .level(level), .full(full),
    .overflow(overflow), .frame_count(frame_count), .irq(irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ws high for one cycle then low: frame end lands in the cycle ws drops (N).
  task automatic do_frame(input logic [63:0] rx, input int pop_at);
    ws = 1'b1;
    tick;
    ws = 1'b0;
    rx_data = rx;
    for (int i = 0; i < 7; i++) begin
      pop = (i == pop_at);
      tick;
    end
    pop = 1'b0;
  endtask

  task automatic do_pop1;
    pop = 1'b1;
    tick;
    pop = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " level"}, 64'(level), 64'd0);
    chk({tag, " rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, " rd_data"}, 64'(rd_data), 64'd0);
    chk({tag, " full"}, 64'(full), 64'd0);
    chk({tag, " overflow"}, 64'(overflow), 64'd0);
    chk({tag, " frame_count"}, 64'(frame_count), 64'd0);
    chk({tag, " irq"}, 64'(irq), 64'd0);
  endtask

  initial begin
    logic [31:0] exp_q [8];

    //          op        mode  thr   rx                      lvl rd            ovf full fc irq
    tbl.push_back('{OP_FRAME, 2'd0, 4'd0, 64'h2222_2222_1111_1111, 0, 32'h0,        0, 0, 0, 0});
    tbl.push_back('{OP_FRAME, 2'd0, 4'd0, 64'h2222_2222_1111_1111, 1, 32'h1111_1111, 0, 0, 1, 0});
    tbl.push_back('{OP_POP,   2'd0, 4'd0, 64'h0,                   0, 32'h0,        0, 0, 1, 0});
    tbl.push_back('{OP_CLR,   2'd0, 4'd0, 64'h0,                   0, 32'h0,        0, 0, 0, 0});
    tbl.push_back('{OP_FRAME, 2'd2, 4'd0, 64'hDEAD_BEEF_0BAD_F00D, 0, 32'h0,        0, 0, 0, 0});
    tbl.push_back('{OP_FRAME, 2'd2, 4'd0, 64'hB000_0000_A000_0000, 2, 32'hA000_0000, 0, 0, 1, 0});
    tbl.push_back('{OP_FRAME, 2'd2, 4'd0, 64'hB100_0000_A100_0000, 4, 32'hA000_0000, 0, 0, 2, 0});
    tbl.push_back('{OP_FRAME, 2'd2, 4'd0, 64'hB200_0000_A200_0000, 6, 32'hA000_0000, 0, 0, 3, 0});
    tbl.push_back('{OP_POP,   2'd2, 4'd0, 64'h0,                   5, 32'hB000_0000, 0, 0, 3, 0});
    tbl.push_back('{OP_POP,   2'd2, 4'd0, 64'h0,                   4, 32'hA100_0000, 0, 0, 3, 0});
    tbl.push_back('{OP_POP,   2'd2, 4'd0, 64'h0,                   3, 32'hB100_0000, 0, 0, 3, 0});
    tbl.push_back('{OP_POP,   2'd2, 4'd0, 64'h0,                   2, 32'hA200_0000, 0, 0, 3, 0});
    tbl.push_back('{OP_POP,   2'd2, 4'd0, 64'h0,                   1, 32'hB200_0000, 0, 0, 3, 0});
    tbl.push_back('{OP_POP,   2'd2, 4'd0, 64'h0,                   0, 32'h0,        0, 0, 3, 0});
    tbl.push_back('{OP_POP,   2'd2, 4'd0, 64'h0,                   0, 32'h0,        0, 0, 3, 0});
    tbl.push_back('{OP_FRAME, 2'd2, 4'd0, 64'hB300_0000_A300_0000, 2, 32'hA300_0000, 0, 0, 4, 0});
    tbl.push_back('{OP_FRAME, 2'd2, 4'd0, 64'hB400_0000_A400_0000, 4, 32'hA300_0000, 0, 0, 5, 0});
    tbl.push_back('{OP_FRAME, 2'd2, 4'd0, 64'hB500_0000_A500_0000, 6, 32'hA300_0000, 0, 0, 6, 0});
    tbl.push_back('{OP_FRAME, 2'd2, 4'd0, 64'hB600_0000_A600_0000, 8, 32'hA300_0000, 0, 1, 7, 0});
    tbl.push_back('{OP_FRAME, 2'd2, 4'd0, 64'hB700_0000_A700_0000, 8, 32'hA300_0000, 1, 1, 8, 0});
    tbl.push_back('{OP_CLR,   2'd0, 4'd4, 64'h0,                   0, 32'h0,        0, 0, 0, 0});
    tbl.push_back('{OP_FRAME, 2'd0, 4'd4, 64'h0000_0000_0000_00C0, 0, 32'h0,        0, 0, 0, 0});
    tbl.push_back('{OP_FRAME, 2'd0, 4'd4, 64'hD100_0000_C100_0000, 1, 32'hC100_0000, 0, 0, 1, 0});
    tbl.push_back('{OP_FRAME, 2'd0, 4'd4, 64'hD200_0000_C200_0000, 2, 32'hC100_0000, 0, 0, 2, 0});
    tbl.push_back('{OP_FRAME, 2'd0, 4'd4, 64'hD300_0000_C300_0000, 3, 32'hC100_0000, 0, 0, 3, 0});
    tbl.push_back('{OP_FRAME, 2'd0, 4'd4, 64'hD400_0000_C400_0000, 4, 32'hC100_0000, 0, 0, 4, 1});
    tbl.push_back('{OP_POP,   2'd0, 4'd4, 64'h0,                   3, 32'hC200_0000, 0, 0, 4, 0});
    tbl.push_back('{OP_FRAME, 2'd0, 4'd0, 64'hD500_0000_C500_0000, 4, 32'hC200_0000, 0, 0, 5, 0});
    tbl.push_back('{OP_FRAME, 2'd0, 4'd0, 64'hD600_0000_C600_0000, 5, 32'hC200_0000, 0, 0, 6, 0});
    tbl.push_back('{OP_FRAME, 2'd3, 4'd0, 64'hD700_0000_C700_0000, 6, 32'hC200_0000, 0, 0, 7, 0});
    tbl.push_back('{OP_FRAME, 2'd1, 4'd0, 64'hD800_0000_C800_0000, 7, 32'hC200_0000, 0, 0, 8, 0});

    HRESET = 1'b1; en = 1'b0; clr = 1'b0; mode = 2'd0; threshold = '0;
    ws = 1'b0; rx_data = '0; pop = 1'b0;
    repeat (3) tick;
    chk_zero("reset");
    HRESET = 1'b0;
    en = 1'b1;
    tick;

    foreach (tbl[i]) begin
      mode      = tbl[i].mode;
      threshold = tbl[i].thr;
      case (tbl[i].op)
        OP_FRAME: do_frame(tbl[i].rx, -1);
        OP_POP:   do_pop1;
        default: begin
          clr = 1'b1;
          tick;
          clr = 1'b0;
        end
      endcase
      chk($sformatf("row%0d level", i), 64'(level), 64'(tbl[i].lvl));
      chk($sformatf("row%0d rd_data", i), 64'(rd_data), 64'(tbl[i].rd));
      chk($sformatf("row%0d rd_valid", i), 64'(rd_valid), 64'(tbl[i].lvl != 0));
      chk($sformatf("row%0d overflow", i), 64'(overflow), 64'(tbl[i].ovf));
      chk($sformatf("row%0d full", i), 64'(full), 64'(tbl[i].full));
      chk($sformatf("row%0d frame_count", i), 64'(frame_count), 64'(tbl[i].fc));
      chk($sformatf("row%0d irq", i), 64'(irq), 64'(tbl[i].irq));
    end

    // Full FIFO, pop coincident with the push
    mode = 2'd0;
    threshold = '0;
    do_frame(64'hEEEE_EEEE_E900_0000, -1);
    chk("fill level", 64'(level), 64'd8);
    chk("fill full", 64'(full), 64'd1);
    do_frame(64'hEEEE_EEEE_EA00_0000, 4);
    chk("pp level", 64'(level), 64'd8);
    chk("pp overflow", 64'(overflow), 64'd0);
    chk("pp head", 64'(rd_data), 64'h0000_0000_C300_0000);
    chk("pp frame_count", 64'(frame_count), 64'd10);
    exp_q = '{32'hC300_0000, 32'hC400_0000, 32'hC500_0000, 32'hC600_0000,
              32'hC700_0000, 32'hD800_0000, 32'hE900_0000, 32'hEA00_0000};
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("drain%0d", k), 64'(rd_data), 64'(exp_q[k]));
      do_pop1;
    end
    chk("drain level", 64'(level), 64'd0);

    // Push latency and irq timing relative to level
    clr = 1'b1;
    tick;
    clr = 1'b0;
    threshold = 4'd1;
    do_frame(64'h0, -1);
    ws = 1'b1;
    tick;
    ws = 1'b0;
    rx_data = 64'h0000_0000_F1F1_F1F1;
    repeat (4) tick;
    chk("lat N+4 level", 64'(level), 64'd0);
    chk("lat N+4 irq", 64'(irq), 64'd0);
    tick;
    chk("lat N+5 level", 64'(level), 64'd1);
    chk("lat N+5 irq", 64'(irq), 64'd1);
    chk("lat N+5 rd_data", 64'(rd_data), 64'h0000_0000_F1F1_F1F1);
    chk("lat frame_count", 64'(frame_count), 64'd1);
    repeat (2) tick;

    // en dropped while waiting out the capture delay
    ws = 1'b1;
    tick;
    ws = 1'b0;
    rx_data = 64'h0000_0000_5555_5555;
    tick;
    en = 1'b0;
    repeat (8) tick;
    chk("abort level", 64'(level), 64'd1);
    chk("abort frame_count", 64'(frame_count), 64'd1);
    en = 1'b1;
    tick;
    do_frame(64'h0000_0000_6666_6666, -1);
    chk("resync discard level", 64'(level), 64'd1);
    do_frame(64'h0000_0000_6666_6666, -1);
    chk("resync level", 64'(level), 64'd2);
    chk("resync frame_count", 64'(frame_count), 64'd2);
    chk("resync head", 64'(rd_data), 64'h0000_0000_F1F1_F1F1);

    // Reset landing in the middle of a stereo push pair
    mode = 2'd2;
    ws = 1'b1;
    tick;
    ws = 1'b0;
    rx_data = 64'h7777_7777_8888_8888;
    repeat (5) tick;
    chk("mid-stereo level", 64'(level), 64'd3);
    HRESET = 1'b1;
    tick;
    HRESET = 1'b0;
    chk_zero("hreset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
